// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM generator.
// Default parameter values, duty-width helper and the per-channel duty record.
// Types only; no logic, no latency, no flow control.

package pwm_pkg;

  // Default build parameters.
  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_PERIOD       = 10;
  localparam int DEF_DEBOUNCE_DIV = 2;
  localparam int DEF_INIT_DUTY    = 5;

  // PERIOD is limited to 255, so every duty value fits in 8 bits. The duty
  // record is stored at this fixed width; values never exceed PERIOD, so the
  // bits above clog2(PERIOD+1) are always zero.
  localparam int DUTY_W_MAX = 8;

  typedef logic [DUTY_W_MAX-1:0] duty_val_t;

  // Per-channel duty state: shadow collects button adjustments at any time,
  // active is what drives the comparator and only changes at a period wrap.
  typedef struct packed {
    duty_val_t shadow;
    duty_val_t active;
  } chan_duty_t;

  // Width of a duty value able to represent 0..period inclusive.
  function automatic int pwm_duty_w(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_btn_edge.sv
// Button sampler: two flops loaded on a shared prescaler tick, one press pulse per debounced rising edge.
// Latency: press asserts during the second tick that sees the button high; held buttons do not repeat.
// No backpressure: press is a single-cycle strobe that the consumer must take when it appears.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   tick     : sampling strobe shared by all buttons
//   btn      : raw, possibly bouncing, button level
//   press    : one-cycle pulse coincident with the tick that confirms the rising edge

module pwm_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (tick) begin
      s1_d = btn;
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Gating with tick keeps the pulse to one cycle even though s1/s2 hold
  // their values for a whole tick interval.
  assign press = s1_q & ~s2_q & tick;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// Multi-channel PWM generator with per-channel debounced inc/dec duty control and glitch-free duty updates.
// Latency: 1 cycle from counter to pwm_out/period_start; new duty takes effect at the channel's next wrap.
// No backpressure: buttons are sampled continuously and outputs are free-running registered levels.
//
// Optional feature macro: PWM_PHASE_STAGGER_EN
//   defined     : channel i counter resets (and reloads when ena rises) to (i*PERIOD)/CHANNELS
//   not defined : one shared period counter starting at 0, all channels edge-aligned
//
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   ena           : run enable; when low, outputs are 0 and counters freeze
//   inc_btn       : raw increment buttons, one per channel
//   dec_btn       : raw decrement buttons, one per channel
//   pwm_out       : registered PWM outputs, one per channel
//   duty          : active duty per channel, DW bits each, channel 0 in the LSBs
//   period_start  : registered one-cycle pulse when a channel counter is 0

module pwm_multi_channel_gen
  import pwm_pkg::*;
#(
  parameter int  CHANNELS     = DEF_CHANNELS,
  parameter int  PERIOD       = DEF_PERIOD,
  parameter int  DEBOUNCE_DIV = DEF_DEBOUNCE_DIV,
  parameter int  INIT_DUTY    = DEF_INIT_DUTY,
  localparam int DW           = pwm_duty_w(PERIOD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [CHANNELS-1:0]    inc_btn,
  input  logic [CHANNELS-1:0]    dec_btn,
  output logic [CHANNELS-1:0]    pwm_out,
  output logic [CHANNELS*DW-1:0] duty,
  output logic [CHANNELS-1:0]    period_start
);

  localparam int CW   = $clog2(PERIOD);
  localparam int DIVW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DEBOUNCE_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
  localparam duty_val_t       PERIOD_V = duty_val_t'(PERIOD);
  localparam duty_val_t       INIT_V   = duty_val_t'(INIT_DUTY);

  // ---------------------------------------------------------------------------
  // Button prescaler: free-running, independent of ena, so presses made while
  // the outputs are disabled are still seen.
  // ---------------------------------------------------------------------------
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic            tick;

  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounced press detectors, two per channel, all on the shared tick.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] inc_press;
  logic [CHANNELS-1:0] dec_press;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_btn
    pwm_btn_edge u_inc (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn   (inc_btn[gi]),
      .press (inc_press[gi])
    );
    pwm_btn_edge u_dec (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn   (dec_btn[gi]),
      .press (dec_press[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Period counters. cnt_cur is the counter value each channel uses this
  // cycle for its comparator, wrap detection and period_start.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_cur [CHANNELS];

`ifdef PWM_PHASE_STAGGER_EN
  logic          ena_q, ena_d;
  logic [CW-1:0] cnt_q [CHANNELS];
  logic [CW-1:0] cnt_d [CHANNELS];

  // On the first enabled cycle each counter restarts from its phase offset,
  // so the stagger pattern is re-established after every pause.
  always_comb begin
    ena_d = ena;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_cur[i] = (ena && !ena_q) ? CW'((i * PERIOD) / CHANNELS) : cnt_q[i];
      cnt_d[i]   = cnt_q[i];
      if (ena) begin
        cnt_d[i] = (cnt_cur[i] == CNT_LAST) ? '0 : cnt_cur[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= CW'((i * PERIOD) / CHANNELS);
      end
    end else begin
      ena_q <= ena_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic [CW-1:0] cnt_q, cnt_d;

  // One counter serves every channel; on resume it continues from where it froze.
  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_cur[i] = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Duty state and registered outputs.
  // ---------------------------------------------------------------------------
  chan_duty_t          chan_q [CHANNELS];
  chan_duty_t          chan_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] period_start_q, period_start_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_d[i] = chan_q[i];

      // Shadow saturates at both ends; simultaneous inc+dec cancel.
      if (inc_press[i] && !dec_press[i] && (chan_q[i].shadow != PERIOD_V)) begin
        chan_d[i].shadow = chan_q[i].shadow + 1'b1;
      end else if (dec_press[i] && !inc_press[i] && (chan_q[i].shadow != '0)) begin
        chan_d[i].shadow = chan_q[i].shadow - 1'b1;
      end

      // Load on the last count so the new value governs the whole next period.
      // The current shadow (not this cycle's update) is taken.
      if (ena && (cnt_cur[i] == CNT_LAST)) begin
        chan_d[i].active = chan_q[i].shadow;
      end

      // Counter is widened to the duty width; active never exceeds PERIOD, so
      // duty PERIOD gives a constant high and duty 0 a constant low.
      pwm_d[i]          = ena & (duty_val_t'(cnt_cur[i]) < chan_q[i].active);
      period_start_d[i] = ena & (cnt_cur[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q          <= '0;
      period_start_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        chan_q[i] <= '{shadow: INIT_V, active: INIT_V};
      end
    end else begin
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < CHANNELS; i++) begin
        chan_q[i] <= chan_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

  always_comb begin
    duty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i*DW +: DW] = chan_q[i].active[DW-1:0];
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Bench for pwm_multi_channel_gen with default parameters (4 channels, period 10, tick every 2 cycles).
// Expected duty per PWM period is queued by the stimulus; a monitor checks it at every period_start.
// With PWM_PHASE_STAGGER_EN defined, the phase spacing of the period_start pulses is checked instead.

module tb_pwm_multi_channel_gen;

  localparam int CH  = 4;
  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  inc_btn;
  logic [3:0]  dec_btn;
  logic [3:0]  pwm_out;
  logic [15:0] duty;
  logic [3:0]  period_start;

  always #5 clk = ~clk;

  pwm_multi_channel_gen #(
    .CHANNELS     (CH),
    .PERIOD       (PER),
    .DEBOUNCE_DIV (2),
    .INIT_DUTY    (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .inc_btn      (inc_btn),
    .dec_btn      (dec_btn),
    .pwm_out      (pwm_out),
    .duty         (duty),
    .period_start (period_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks();
    chk("rst_pwm_out", 16'(pwm_out), 16'h0000);
    chk("rst_duty", duty, 16'h5555);
    chk("rst_period_start", 16'(period_start), 16'h0000);
  endtask

`ifndef PWM_PHASE_STAGGER_EN
  // Scoreboard: one entry per PWM period, holding the duty bus expected for it.
  logic [15:0] sb_q [$];
  bit          mon_en    = 1'b0;
  bit          stim_done = 1'b0;
  bit          mon_done  = 1'b0;
  logic        ena_at_edge = 1'b1;

  always @(posedge clk) ena_at_edge <= ena;

  // Called #1 after an edge; returns #1 after the next edge that produced a period_start.
  task automatic wait_ps();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (period_start != 4'h0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL ps_timeout: no period_start within 40 cycles, one required");
  endtask

  // One full period: queue its expectation, hold buttons for 6 cycles, with an
  // optional 1-cycle inc glitch landing on a non-tick edge.
  task automatic run_period(input logic [15:0] exp, input logic [3:0] inc,
                            input logic [3:0] dec, input logic [3:0] gl);
    sb_q.push_back(exp);
    for (int c = 0; c < 6; c++) begin
      inc_btn = inc | ((c == 1) ? gl : 4'h0);
      dec_btn = dec;
      @(posedge clk);
      #1;
    end
    inc_btn = 4'h0;
    dec_btn = 4'h0;
    wait_ps();
  endtask

  // Period interrupted by a 7-cycle ena low window, with an inc press inside it.
  task automatic run_gap(input logic [15:0] exp, input logic [3:0] inc);
    sb_q.push_back(exp);
    repeat (2) @(posedge clk);
    #1;
    ena     = 1'b0;
    inc_btn = inc;
    repeat (6) @(posedge clk);
    #1;
    inc_btn = 4'h0;
    @(posedge clk);
    #1;
    ena = 1'b1;
    wait_ps();
  endtask

  // Monitor: at each period_start pops the expected duty, checks the duty bus,
  // and checks that each channel was high exactly duty cycles in that period.
  initial begin : monitor
    logic [15:0] cur;
    bit          have;
    int          hi [CH];
    have = 1'b0;
    cur  = '0;
    foreach (hi[c]) hi[c] = 0;
    wait (mon_en);
    while (!mon_done) begin
      @(negedge clk);
      if (!ena_at_edge) begin
        chk("ena_low_pwm_out", 16'(pwm_out), 16'h0000);
        chk("ena_low_period_start", 16'(period_start), 16'h0000);
      end
      if (period_start != 4'h0) begin
        chk("period_start_aligned", 16'(period_start), 16'h000F);
        if (have) begin
          for (int c = 0; c < CH; c++) begin
            chk($sformatf("high_cycles_ch%0d", c), 16'(hi[c]), {12'h000, cur[c*4 +: 4]});
          end
        end
        if (sb_q.size() == 0) begin
          have = 1'b0;
          if (stim_done) begin
            mon_done = 1'b1;
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_period: period_start with empty scoreboard (t=%0t)", $time);
          end
        end else begin
          cur  = sb_q.pop_front();
          have = 1'b1;
          chk("duty_bus", duty, cur);
        end
        foreach (hi[c]) hi[c] = 0;
      end
      if (have) begin
        for (int c = 0; c < CH; c++) begin
          if (pwm_out[c]) hi[c]++;
        end
      end
    end
  end

  // Expected duty bus per period, channel 0 in the low nibble.
  logic [15:0] exp_tab [21] = '{
    16'h5555, 16'h5565, 16'h5566, 16'h5567, 16'h5568, 16'h5569, 16'h556A,
    16'h556A, 16'h5569, 16'h5568, 16'h5567, 16'h5566, 16'h5565, 16'h5564,
    16'h5563, 16'h5562, 16'h5561, 16'h5560, 16'h5560, 16'h5560, 16'h5560
  };

  initial begin : stim
    logic [3:0] inc, dec, gl;
    rst     = 1'b1;
    ena     = 1'b0;
    inc_btn = 4'h0;
    dec_btn = 4'h0;
    #12;
    reset_checks();

    // Run briefly with an inc press on channel 0, then reset mid-period.
    @(posedge clk);
    #3;
    rst     = 1'b0;
    ena     = 1'b1;
    inc_btn = 4'b0001;
    repeat (6) @(posedge clk);
    #1;
    inc_btn = 4'h0;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_duty", duty, 16'h5556);
    chk("pre_rst_pwm_out", 16'(pwm_out), 16'h000F);
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    #3;
    reset_checks();
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_ps();

    // Channel 1 single inc, channel 0 to saturation and back to 0,
    // simultaneous inc/dec on channel 2 plus an inc glitch on channel 3.
    for (int i = 0; i < 21; i++) begin
      inc = (i == 0) ? 4'b0010 : (i <= 6) ? 4'b0001 : (i == 19) ? 4'b0100 : 4'b0000;
      dec = (i >= 7 && i <= 18) ? 4'b0001 : (i == 19) ? 4'b0100 : 4'b0000;
      gl  = (i == 19) ? 4'b1000 : 4'b0000;
      run_period(exp_tab[i], inc, dec, gl);
    end

    // ena pause with a channel 3 press inside it; visible after the next wrap.
    run_gap(16'h5560, 4'b1000);
    run_period(16'h6560, 4'h0, 4'h0, 4'h0);

    stim_done = 1'b1;
    for (int c = 0; c < 40 && !mon_done; c++) @(posedge clk);
    if (!mon_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL monitor_drain: final period never closed");
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

`else
  // Stagger build: each channel pulses once per period; channel 0 pulses
  // 0, 2, 5 and 7 cycles after channels 0..3 respectively.
  initial begin : stim
    int last [CH];
    int npulse [CH];
    int nhigh [CH];
    int offs [CH] = '{0, 2, 5, 7};
    rst     = 1'b1;
    ena     = 1'b0;
    inc_btn = 4'h0;
    dec_btn = 4'h0;
    foreach (last[c]) begin
      last[c]   = 0;
      npulse[c] = 0;
      nhigh[c]  = 0;
    end
    #12;
    reset_checks();
    @(posedge clk);
    #3;
    rst = 1'b0;
    ena = 1'b1;
    for (int t = 0; t < 3 * PER; t++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (period_start[c]) begin
          last[c] = t;
          npulse[c]++;
        end
        if (pwm_out[c]) nhigh[c]++;
      end
    end
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("stagger_pulses_ch%0d", c), 16'(npulse[c]), 16'd3);
      chk($sformatf("stagger_high_ch%0d", c), 16'(nhigh[c]), 16'd15);
      chk($sformatf("stagger_phase_ch%0d", c),
          16'((((last[0] - last[c]) % PER) + PER) % PER), 16'(offs[c]));
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
`endif

endmodule
